// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the CPU inter-stage elastic pipeline registers.
//   cnt_w(depth)  - width of an occupancy counter able to hold 0..depth
//   ptr_w(depth)  - width of an index into a depth-entry buffer (at least 1 bit)
//   DEFAULT_*     - default payload width / depth of a stage register
//   *_WIDTH       - payload widths of the four CPU stage boundaries
package pipe_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam int unsigned DEFAULT_DEPTH = 2;

    // Stage boundary payloads: control and data fields concatenated
    localparam int unsigned IF_ID_WIDTH  = 64;   // pc, instruction
    localparam int unsigned ID_EX_WIDTH  = 150;  // pc, rs1/rs2 data, imm, rd, ctrl
    localparam int unsigned EX_MEM_WIDTH = 106;  // alu result, store data, rd, ctrl
    localparam int unsigned MEM_WB_WIDTH = 72;   // wb data, rd, ctrl

    localparam int unsigned IF_ID_DEPTH  = DEFAULT_DEPTH;
    localparam int unsigned ID_EX_DEPTH  = DEFAULT_DEPTH;
    localparam int unsigned EX_MEM_DEPTH = DEFAULT_DEPTH;
    localparam int unsigned MEM_WB_DEPTH = DEFAULT_DEPTH;

    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // A one-entry buffer still needs a 1-bit pointer to form a legal vector
    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/ring_ptr.sv
// ring_ptr: modulo-DEPTH pointer with increment and clear.
//   clk  - clock
//   rst  - synchronous active-low reset (pointer to 0)
//   clr  - return pointer to 0 on the next edge (wins over inc)
//   inc  - advance pointer by one, wrapping DEPTH-1 -> 0
//   ptr  - current pointer value
module ring_ptr
    import pipe_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      inc,
    output logic [ptr_w(DEPTH)-1:0]   ptr
);

    localparam int unsigned PTR_W = ptr_w(DEPTH);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0] ptr_q, ptr_d;

    // Explicit compare against the last slot so non-power-of-two depths wrap correctly
    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = (ptr_q == LAST) ? '0 : ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/elastic_pipe_reg.sv
// elastic_pipe_reg: WIDTH-bit, DEPTH-entry elastic pipeline register (ring buffer)
// with valid/ready handshakes on both sides and a squash (flush) input.
//   clk, rst            - clock, synchronous active-low reset
//   in_valid/in_ready   - upstream handshake, in_data is the payload
//   out_valid/out_ready - downstream handshake, out_data is the head entry
//   flush               - drop all held entries on the next edge
//   count               - current occupancy
// Build option: define ELASTIC_BYPASS_EN to add a zero-latency combinational path
// from in_data to out_data when the buffer is empty and downstream is ready.
module elastic_pipe_reg
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    input  logic                      flush,
    output logic [cnt_w(DEPTH)-1:0]   count
);

    localparam int unsigned CNT_W = cnt_w(DEPTH);
    localparam int unsigned PTR_W = ptr_w(DEPTH);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count_q, count_d;
    logic             buf_valid;
    logic             bypass;
    logic             push, pop;

    assign buf_valid = (count_q != '0);
    // Ready depends only on occupancy, so a full buffer never takes a push alongside a pop
    assign in_ready  = rst && (count_q < FULL);

`ifdef ELASTIC_BYPASS_EN
    assign bypass    = rst && !buf_valid && in_valid && out_ready && !flush;
    assign out_valid = buf_valid || bypass;
    assign out_data  = bypass ? in_data : mem[rd_ptr];
`else
    assign bypass    = 1'b0;
    assign out_valid = buf_valid;
    assign out_data  = mem[rd_ptr];
`endif

    // A bypassed entry is a push and pop that cancel: nothing touches the array
    assign push = in_valid && in_ready && !bypass;
    assign pop  = buf_valid && out_ready;

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Flush leaves array contents alone; only reset zeroes them
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (push && !flush) begin
            mem[wr_ptr] <= in_data;
        end
    end

    ring_ptr #(
        .DEPTH (DEPTH)
    ) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (push),
        .ptr (wr_ptr)
    );

    ring_ptr #(
        .DEPTH (DEPTH)
    ) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (pop),
        .ptr (rd_ptr)
    );

    assign count = count_q;

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Bench for elastic_pipe_reg: a DEPTH=2 instance (a) and a DEPTH=3 instance (b),
// each with a queue scoreboard filled on accepted pushes and drained on pops.
module tb_elastic_pipe_reg;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;

    logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush;
    logic [W-1:0] a_in_data, a_out_data;
    logic [1:0]   a_count;

    logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush;
    logic [W-1:0] b_in_data, b_out_data;
    logic [1:0]   b_count;

    int           n_checks = 0;
    int           n_fail   = 0;
    bit           mon_en   = 1'b0;

    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    logic [W-1:0] exp_a, exp_b;
    logic         a_push, a_pop, a_byp, a_empty;
    logic         b_push, b_pop, b_byp, b_empty;
    int           b_pops = 0;
    int           b_max  = 0;

    always #5 clk = ~clk;

    elastic_pipe_reg #(
        .WIDTH (W),
        .DEPTH (2)
    ) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data),
        .flush     (a_flush),
        .count     (a_count)
    );

    elastic_pipe_reg #(
        .WIDTH (W),
        .DEPTH (3)
    ) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .flush     (b_flush),
        .count     (b_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

`ifdef ELASTIC_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    // Scoreboard for instance a, sampled mid-cycle while inputs and outputs are stable
    always @(negedge clk) begin
        if (mon_en) begin
            a_empty = (qa.size() == 0);
            a_byp   = BYP && rst && a_empty && a_in_valid && a_out_ready && !a_flush;
            check("a_count", 32'(a_count), 32'(qa.size()));
            check("a_in_ready", 32'(a_in_ready), 32'(rst && qa.size() < 2));
            check("a_out_valid", 32'(a_out_valid), 32'(!a_empty || a_byp));
            a_push = a_in_valid && a_in_ready;
            a_pop  = a_out_valid && a_out_ready;
            if (!rst) begin
                qa.delete();
            end else begin
                if (a_pop) begin
                    if (!a_empty) begin
                        exp_a = qa.pop_front();
                        check("a_out_data", 32'(a_out_data), 32'(exp_a));
                    end else begin
                        check("a_bypass_data", 32'(a_out_data), 32'(a_in_data));
                    end
                end
                if (a_push && !a_flush && !(a_pop && a_empty)) qa.push_back(a_in_data);
                if (a_flush) qa.delete();
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            b_empty = (qb.size() == 0);
            b_byp   = BYP && rst && b_empty && b_in_valid && b_out_ready && !b_flush;
            check("b_count", 32'(b_count), 32'(qb.size()));
            check("b_in_ready", 32'(b_in_ready), 32'(rst && qb.size() < 3));
            check("b_out_valid", 32'(b_out_valid), 32'(!b_empty || b_byp));
            if (int'(b_count) > b_max) b_max = int'(b_count);
            b_push = b_in_valid && b_in_ready;
            b_pop  = b_out_valid && b_out_ready;
            if (!rst) begin
                qb.delete();
            end else begin
                if (b_pop) begin
                    b_pops++;
                    if (!b_empty) begin
                        exp_b = qb.pop_front();
                        check("b_out_data", 32'(b_out_data), 32'(exp_b));
                    end else begin
                        check("b_bypass_data", 32'(b_out_data), 32'(b_in_data));
                    end
                end
                if (b_push && !b_flush && !(b_pop && b_empty)) qb.push_back(b_in_data);
                if (b_flush) qb.delete();
            end
        end
    end

    initial begin
        int  i;
        int  cyc;
        bit  tog;
        bit  acc;

        rst = 1'b0;
        a_in_valid = 1'b1; a_in_data = 8'h5A; a_out_ready = 1'b0; a_flush = 1'b0;
        b_in_valid = 1'b1; b_in_data = 8'hA5; b_out_ready = 1'b0; b_flush = 1'b0;

        // Reset held three cycles with in_valid asserted
        tick();
        mon_en = 1'b1;
        tick();
        tick();
        check("rst_a_in_ready", 32'(a_in_ready), 32'd0);
        check("rst_a_out_valid", 32'(a_out_valid), 32'd0);
        check("rst_a_out_data", 32'(a_out_data), 32'd0);
        check("rst_a_count", 32'(a_count), 32'd0);
        check("rst_b_out_data", 32'(b_out_data), 32'd0);
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rel_a_in_ready", 32'(a_in_ready), 32'd1);
        check("rel_b_in_ready", 32'(b_in_ready), 32'd1);

        // Fill and drain, DEPTH=2
        a_in_valid = 1'b1; a_in_data = 8'h0A;
        tick();
        a_in_data = 8'h0B;
        tick();
        a_in_valid = 1'b0;
        check("fill_count", 32'(a_count), 32'd2);
        check("fill_in_ready", 32'(a_in_ready), 32'd0);
        check("fill_head", 32'(a_out_data), 32'h0A);
        a_out_ready = 1'b1;
        tick();
        check("drain_second", 32'(a_out_data), 32'h0B);
        tick();
        check("drain_empty", 32'(a_out_valid), 32'd0);
        a_out_ready = 1'b0;

        // Wrap-around, DEPTH=3: stream 0..9 with out_ready toggling
        i = 0; tog = 1'b0;
        for (cyc = 0; cyc < 200 && i < 10; cyc++) begin
            b_in_valid  = 1'b1;
            b_in_data   = W'(i);
            b_out_ready = tog;
            tog = ~tog;
            #1;
            acc = b_in_ready;
            tick();
            if (acc) i++;
        end
        check("wrap_all_pushed", 32'(i), 32'd10);
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;
        for (cyc = 0; cyc < 20 && b_count != 0; cyc++) tick();
        tick();
        b_out_ready = 1'b0;
        check("wrap_pops", 32'(b_pops), 32'd10);
        check("wrap_max_count_le3", 32'(b_max <= 3), 32'd1);

        // Flush together with a push while holding 0x11, 0x22
        a_in_valid = 1'b1; a_in_data = 8'h11;
        tick();
        a_in_data = 8'h22;
        tick();
        a_in_data = 8'h33; a_flush = 1'b1;
        tick();
        a_flush = 1'b0; a_in_valid = 1'b0;
        check("flush_count", 32'(a_count), 32'd0);
        check("flush_out_valid", 32'(a_out_valid), 32'd0);
        a_out_ready = 1'b1;
        tick();
        tick();
        a_out_ready = 1'b0;

        // Simultaneous push and pop at count 1
        a_in_valid = 1'b1; a_in_data = 8'h04;
        tick();
        a_in_data = 8'h05; a_out_ready = 1'b1;
        tick();
        a_in_valid = 1'b0; a_out_ready = 1'b0;
        check("pp_count", 32'(a_count), 32'd1);
        check("pp_head", 32'(a_out_data), 32'h05);
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;

        // Empty buffer, valid input, ready output
        a_in_valid = 1'b1; a_in_data = 8'h77; a_out_ready = 1'b1;
        #1;
`ifdef ELASTIC_BYPASS_EN
        check("byp_out_valid", 32'(a_out_valid), 32'd1);
        check("byp_out_data", 32'(a_out_data), 32'h77);
        check("byp_count", 32'(a_count), 32'd0);
        tick();
        a_in_valid = 1'b0;
        check("byp_count_after", 32'(a_count), 32'd0);
`else
        check("nobyp_out_valid", 32'(a_out_valid), 32'd0);
        tick();
        a_in_valid = 1'b0;
        check("nobyp_out_data", 32'(a_out_data), 32'h77);
`endif
        tick();
        a_out_ready = 1'b0;

        // Reset during a transfer discards everything and zeroes the array
        b_in_valid = 1'b1; b_in_data = 8'hC3;
        tick();
        b_in_data = 8'h3C;
        tick();
        b_in_valid = 1'b0;
        check("mid_b_count", 32'(b_count), 32'd2);
        rst = 1'b0;
        tick();
        check("mid_rst_count", 32'(b_count), 32'd0);
        check("mid_rst_out_valid", 32'(b_out_valid), 32'd0);
        check("mid_rst_out_data", 32'(b_out_data), 32'd0);
        check("mid_rst_in_ready", 32'(b_in_ready), 32'd0);
        rst = 1'b1;
        tick();
        tick();

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
